if_fetch_unit: RTL and testbench

Instruction-fetch stage of the ARM pipeline, directly upstream of the decode stage. It owns the program counter and issues requests to a variable-latency instruction memory over a req/ack handshake. It delivers {instruction, PC+4} pairs with a valid flag into the IF/ID boundary, honours the hazard-unit freeze, and redirects on taken branches from EXE, squashing any in-flight fetch.

---
 rtl/arm_pkg.sv | 17 +
 rtl/if_fetch_unit_fetch_slot.sv | 33 +++
 rtl/if_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: fetch FSM states, instruction size and default width.
`default_nettype none

package arm_pkg;

   localparam int N_DEFAULT   = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      IDLE   = 2'd1,
      SQUASH = 2'd2
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit_fetch_slot.sv
// FetchSlot: {instruction, pc+4, valid} register with clear (priority), load and hold.
`default_nettype none

module FetchSlot
   import arm_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         load,
   input  logic [N-1:0] instr_d,
   input  logic [N-1:0] pc_d,
   output logic [N-1:0] instr_q,
   output logic [N-1:0] pc_q,
   output logic         valid_q
);

   always_ff @(posedge clk) begin
      if (clear) begin
         instr_q <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and instruction fetcher with branch squash and decode freeze.
// Defining IF_PREFETCH_BUF_EN adds a one-entry prefetch buffer behind the output slot.
`default_nettype none

module if_fetch_unit
   import arm_pkg::*;
#(
   parameter int           N        = N_DEFAULT,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         freezeIn,
   input  logic         branchTakenIn,
   input  logic [N-1:0] branchAddrIn,
   output logic         imemReqOut,
   output logic [N-1:0] imemAddrOut,
   input  logic         imemAckIn,
   input  logic [N-1:0] imemDataIn,
   output logic [N-1:0] instructionOut,
   output logic [N-1:0] PCOut,
   output logic         validOut
);

   localparam logic [N-1:0] PC_STEP = N'(INSTR_BYTES);

   fetch_state_t state;
   fetch_state_t state_next;

   logic [N-1:0] pc;
   logic [N-1:0] pc_plus;
   logic [N-1:0] squash_addr;

   logic         consume;
   logic         accept;
   logic         slot_load;
   logic         slot_clear;
   logic [N-1:0] slot_instr_d;
   logic [N-1:0] slot_pc_d;
   logic         storage_full_next;

   assign pc_plus = pc + PC_STEP;
   assign consume = validOut & ~freezeIn;
   // An ack is only taken into storage from FETCH; SQUASH acks are discarded.
   assign accept  = (state == FETCH) & imemAckIn & ~branchTakenIn;

`ifdef IF_PREFETCH_BUF_EN
   logic         buf_valid;
   logic [N-1:0] buf_instr;
   logic [N-1:0] buf_pc;
   logic         buf_load;
   logic         buf_clear;
   logic         refill;

   // The buffer refills a consumed slot ahead of a same-cycle ack.
   assign refill       = consume & buf_valid;
   assign slot_load    = refill | (accept & (~validOut | consume));
   assign slot_instr_d = refill ? buf_instr : imemDataIn;
   assign slot_pc_d    = refill ? buf_pc    : pc_plus;
   assign slot_clear   = rst | branchTakenIn | (consume & ~slot_load);

   assign buf_load  = accept & validOut & (~consume | buf_valid);
   assign buf_clear = rst | branchTakenIn | (refill & ~buf_load);

   assign storage_full_next = (slot_load | (validOut & ~consume)) &
                              (buf_load  | (buf_valid & ~consume));

   FetchSlot #(.N(N)) u_buf (
      .clk     (clk),
      .clear   (buf_clear),
      .load    (buf_load),
      .instr_d (imemDataIn),
      .pc_d    (pc_plus),
      .instr_q (buf_instr),
      .pc_q    (buf_pc),
      .valid_q (buf_valid)
   );
`else
   // Without a buffer FETCH is only held while the slot is free, so an ack always lands.
   assign slot_load    = accept;
   assign slot_instr_d = imemDataIn;
   assign slot_pc_d    = pc_plus;
   assign slot_clear   = rst | branchTakenIn | (consume & ~slot_load);

   assign storage_full_next = slot_load | (validOut & ~consume);
`endif

   FetchSlot #(.N(N)) u_slot (
      .clk     (clk),
      .clear   (slot_clear),
      .load    (slot_load),
      .instr_d (slot_instr_d),
      .pc_d    (slot_pc_d),
      .instr_q (instructionOut),
      .pc_q    (PCOut),
      .valid_q (validOut)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (branchTakenIn) begin
         // An unacknowledged request must run to completion before the new PC is issued.
         if ((state != IDLE) && !imemAckIn) begin
            state_next = SQUASH;
         end else begin
            state_next = FETCH;
         end
      end else begin
         case (state)
            FETCH, IDLE: state_next = storage_full_next ? IDLE : FETCH;
            SQUASH:      state_next = imemAckIn ? FETCH : SQUASH;
            default:     state_next = FETCH;
         endcase
      end
   end

   always_comb begin
      imemReqOut  = 1'b0;
      imemAddrOut = pc;
      if (((state == FETCH) || (state == SQUASH)) && !rst) begin
         imemReqOut = 1'b1;
      end
      if (state == SQUASH) begin
         imemAddrOut = squash_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (branchTakenIn) begin
         pc <= branchAddrIn;
      end else if (accept) begin
         pc <= pc_plus;
      end
   end

   // Captures the address of the abandoned request so it stays on the bus until acked.
   always_ff @(posedge clk) begin
      if (rst) begin
         squash_addr <= RESET_PC;
      end else if ((state == FETCH) && (state_next == SQUASH)) begin
         squash_addr <= pc;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: queue-based reference model, directed scenarios, then random traffic.
`default_nettype none

module tb_if_fetch_unit;

   localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
`ifdef IF_PREFETCH_BUF_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freezeIn = 1'b0;
   logic        branchTakenIn = 1'b0;
   logic [31:0] branchAddrIn = '0;
   logic        imemAckIn = 1'b0;
   logic [31:0] imemDataIn = '0;
   logic        imemReqOut;
   logic [31:0] imemAddrOut;
   logic [31:0] instructionOut;
   logic [31:0] PCOut;
   logic        validOut;

   if_fetch_unit #(.N(32), .RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .freezeIn       (freezeIn),
      .branchTakenIn  (branchTakenIn),
      .branchAddrIn   (branchAddrIn),
      .imemReqOut     (imemReqOut),
      .imemAddrOut    (imemAddrOut),
      .imemAckIn      (imemAckIn),
      .imemDataIn     (imemDataIn),
      .instructionOut (instructionOut),
      .PCOut          (PCOut),
      .validOut       (validOut)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Model: FIFO of delivered-but-unconsumed {instr, pc+4}, next fetch PC, request flag,
   // and a pending-discard flag with the address of the request being discarded.
   logic [63:0] m_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_sq_addr;
   bit          m_req;
   bit          m_disc;

   int mem_lat    = 0;
   int cur_lat    = 0;
   int wait_cnt   = 0;
   bit mem_rand   = 0;
   bit data_fixed = 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic sample();
      @(negedge clk);
      chk("req", {31'd0, imemReqOut}, {31'd0, m_req && !rst});
      chk("valid", {31'd0, validOut}, {31'd0, m_q.size() > 0});
      if (!rst) chk("addr", imemAddrOut, m_disc ? m_sq_addr : m_pc);
      if (m_q.size() > 0) begin
         chk("instr", instructionOut, m_q[0][63:32]);
         chk("pcout", PCOut, m_q[0][31:0]);
      end
   endtask

   task automatic model_step();
      if (rst) begin
         m_q.delete();
         m_pc   = RST_PC;
         m_req  = 1;
         m_disc = 0;
      end else if (branchTakenIn) begin
         m_q.delete();
         if (m_disc) begin
            if (imemAckIn) m_disc = 0;
         end else if (m_req && !imemAckIn) begin
            m_disc    = 1;
            m_sq_addr = m_pc;
         end
         m_req = 1;
         m_pc  = branchAddrIn;
      end else if (m_disc) begin
         if (imemAckIn) m_disc = 0;
      end else begin
         if (m_q.size() > 0 && !freezeIn) void'(m_q.pop_front());
         if (m_req && imemAckIn) begin
            m_q.push_back({imemDataIn, m_pc + 32'd4});
            m_pc = m_pc + 32'd4;
         end
         m_req = (m_q.size() < CAP);
      end
   endtask

   task automatic mem_drive();
      if (imemReqOut) begin
         if (wait_cnt >= cur_lat) begin
            imemAckIn  = 1'b1;
            imemDataIn = data_fixed ? (32'hA000_0000 + imemAddrOut) : $urandom();
            wait_cnt   = 0;
            cur_lat    = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
         end else begin
            imemAckIn = 1'b0;
            wait_cnt++;
         end
      end else begin
         imemAckIn = 1'b0;
         wait_cnt  = 0;
      end
   endtask

   task automatic drive(input bit r, input bit f, input bit b, input logic [31:0] ba);
      rst           = r;
      freezeIn      = f;
      branchTakenIn = b;
      branchAddrIn  = ba;
      #1;
      mem_drive();
      @(posedge clk);
      model_step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          found;
      bit          acked;
      int          cnt;
      int          held;
      logic [63:0] exp_head;
      logic [31:0] ba;

      drive(1, 0, 0, 32'h0);
      drive(1, 0, 0, 32'h0);
      sample();
      chk("rst_valid", {31'd0, validOut}, 32'd0);
      chk("rst_instr", instructionOut, 32'd0);
      chk("rst_pcout", PCOut, 32'd0);
      chk("rst_addr", imemAddrOut, 32'hFFFF_FFFC);

      // Zero-wait memory from the wrapping reset PC.
      mem_lat = 0; cur_lat = 0; data_fixed = 1;
      drive(0, 0, 0, 32'h0);
      sample();
      chk("first_valid", {31'd0, validOut}, 32'd1);
      chk("first_pcout", PCOut, 32'h0000_0000);
      chk("first_instr", instructionOut, 32'h9FFF_FFFC);
      chk("second_addr", imemAddrOut, 32'h0000_0000);
      chk("second_req", {31'd0, imemReqOut}, (CAP == 2) ? 32'd1 : 32'd0);

      for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 32'h0); sample(); end
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 0, 32'h0);
         sample();
         cnt += int'(validOut);
      end
      chk("rate", cnt, (CAP == 2) ? 32'd10 : 32'd5);

      // Freeze held for five cycles with a live instruction.
      for (int i = 0; i < 10 && !validOut; i++) begin drive(0, 0, 0, 32'h0); sample(); end
      exp_head = (m_q.size() > 0) ? m_q[0] : 64'd0;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) sample();
         chk("frz_instr", instructionOut, exp_head[63:32]);
         chk("frz_pcout", PCOut, exp_head[31:0]);
         drive(0, 1, 0, 32'h0);
         cnt += int'(imemAckIn);
      end
      sample();
      chk("frz_acks", cnt, CAP - 1);
      chk("frz_req_drop", {31'd0, imemReqOut}, 32'd0);
      chk("frz_valid", {31'd0, validOut}, 32'd1);

      // Branch and freeze together with a live instruction.
      drive(0, 1, 1, 32'h200);
      sample();
      chk("brfrz_valid", {31'd0, validOut}, 32'd0);
      chk("brfrz_addr", imemAddrOut, 32'h200);
      chk("brfrz_req", {31'd0, imemReqOut}, 32'd1);

      // Three-cycle memory; branch to 0x100 while the fetch at 8 is outstanding.
      mem_lat = 3; cur_lat = 3; wait_cnt = 0;
      drive(0, 0, 1, 32'h0);
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         sample();
         if (imemReqOut && imemAddrOut == 32'h8 && wait_cnt == 0) found = 1;
         else drive(0, 0, 0, 32'h0);
      end
      if (!found) chk("squash_setup_timeout", 32'd0, 32'd1);
      drive(0, 0, 1, 32'h100);
      held = 0; acked = 0;
      for (int i = 0; i < 8 && !acked; i++) begin
         sample();
         chk("squash_addr", imemAddrOut, 32'h8);
         chk("squash_valid", {31'd0, validOut}, 32'd0);
         held++;
         drive(0, 0, 0, 32'h0);
         acked = imemAckIn;
      end
      chk("squash_len", held, 32'd3);
      sample();
      chk("redirect_addr", imemAddrOut, 32'h100);
      chk("redirect_req", {31'd0, imemReqOut}, 32'd1);
      for (int i = 0; i < 10 && !validOut; i++) begin drive(0, 0, 0, 32'h0); sample(); end
      chk("redirect_pcout", PCOut, 32'h104);
      chk("redirect_instr", instructionOut, 32'hA000_0100);

      // Reset in the middle of a request.
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (imemReqOut && wait_cnt == 1) found = 1;
         else begin drive(0, 0, 0, 32'h0); sample(); end
      end
      if (!found) chk("rst_mid_timeout", 32'd0, 32'd1);
      drive(1, 0, 0, 32'h0);
      sample();
      chk("rst_mid_req", {31'd0, imemReqOut}, 32'd0);
      chk("rst_mid_valid", {31'd0, validOut}, 32'd0);
      drive(0, 0, 0, 32'h0);
      sample();
      chk("restart_req", {31'd0, imemReqOut}, 32'd1);
      chk("restart_addr", imemAddrOut, 32'hFFFF_FFFC);

      // Random traffic checked against the model every cycle.
      mem_rand = 1; data_fixed = 0;
      for (int i = 0; i < 3000; i++) begin
         ba = $urandom();
         ba[1:0] = 2'b00;
         if ($urandom_range(0, 9) == 0) ba = 32'hFFFF_FFFC;
         drive($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 30,
               $urandom_range(0, 99) < 6, ba);
         sample();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire
